bitstream_decoder: RTL and testbench
====================================

BITSTREAM_DECODER -- requirements
Module: bitstream_decoder

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 16: counting window is 2^WINDOW_LOG2 bitstream samples.
REQ-002 SHALL have parameter OUT_WIDTH, default 8: width of the binary result; legal range 1..WINDOW_LOG2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: request one conversion window.
REQ-006 SHALL have port x, input, 1: unipolar stochastic bitstream, one sample per clk.
REQ-007 SHALL have port y, output, OUT_WIDTH: decoded probability, scaled to 0..2^OUT_WIDTH-1.
REQ-008 SHALL have port valid, output, 1: y holds an unconsumed result.
REQ-009 SHALL have port ready, input, 1: consumer accepts y.
REQ-010 SHALL have port busy, output, 1: a window is in progress.
REQ-011 SHALL have port overrun, output, 1: sticky; an unconsumed result was overwritten (continuous mode only, else tied 0).

Function
REQ-012 SHALL implement states IDLE, COUNT, DONE.
REQ-013 IDLE: start=1 -> COUNT; the x sample in the start cycle SHALL NOT be counted.
REQ-014 COUNT SHALL sample x on exactly 2^WINDOW_LOG2 consecutive cycles, beginning the cycle after start, with busy=1 throughout.
REQ-015 The ones counter SHALL be WINDOW_LOG2+1 bits wide, so the all-ones count 2^WINDOW_LOG2 is representable without wrap.
REQ-016 The sample counter SHALL be WINDOW_LOG2 bits wide; the window ends on the cycle it reaches all-ones, and that cycle's sample is counted.
REQ-017 At window end, y SHALL be loaded with min(C >> (WINDOW_LOG2-OUT_WIDTH), 2^OUT_WIDTH-1), where C is the final ones count.
REQ-018 Latency: valid SHALL rise on the cycle after the last counted sample.
REQ-019 valid SHALL stay high and y SHALL stay stable until a cycle with valid=1 and ready=1; valid falls on the next cycle.
REQ-020 DONE with valid&&ready SHALL go to IDLE; start in COUNT or DONE SHALL be ignored.
REQ-021 ready while valid=0 SHALL have no effect.
REQ-022 Counters SHALL clear on every entry to COUNT; no carry between windows.

Reset
REQ-023 rst=1 SHALL force IDLE and clear both counters, y=0, valid=0, busy=0, overrun=0 on the next edge.
REQ-024 rst SHALL take priority over start, ready and window end in the same cycle.
REQ-025 rst asserted mid-window SHALL discard the partial count with no valid pulse.

Configuration
REQ-026 Macro BSDEC_CONTINUOUS_EN SHALL select the windowing mode.
REQ-027 With BSDEC_CONTINUOUS_EN defined:
- after the first start, windows run back-to-back with no gap;
- each window end loads y and sets valid, and the next window's first sample is the following cycle;
- DONE is not entered and busy stays 1;
- if valid is still 1 and not being accepted when a new result loads, overrun SHALL set (sticky until rst) and y is overwritten;
- ready on the same cycle as window end SHALL count as accepting the old result, with no overrun.
REQ-028 Without BSDEC_CONTINUOUS_EN, the one-shot behaviour of REQ-012..REQ-022 applies and overrun SHALL be constant 0.

Structure
REQ-029 Package bsdec_pkg SHALL hold the state enum typedef (IDLE/COUNT/DONE) and the default WINDOW_LOG2/OUT_WIDTH localparams.
REQ-030 No sub-module; counters, FSM and scaling SHALL live in bitstream_decoder. The bench drives x from the existing generator16.

Verification
REQ-031 The bench SHALL cover these scenarios (REQ-031a uses default parameters; REQ-031b..REQ-031f use WINDOW_LOG2=4, OUT_WIDTH=4):
a) x=1 constantly, one start, ready=1 -> y=255 (saturated, C=65536), valid one cycle, busy high 65536 cycles.
b) x=0 constantly -> y=0. x alternating 1/0 -> C=8, y=8.
c) Generator-driven x at p=0.75 -> y within ±1 of 12.
d) ready held 0 for 20 cycles after valid -> valid and y stable for 20 cycles, valid falls the cycle after ready rises, state returns to IDLE.
e) rst pulsed at sample 7 of a window -> no valid, all outputs 0, and a new start converts correctly.
f) BSDEC_CONTINUOUS_EN defined, ready=0, x=1 -> first result valid with y=15; second window end sets overrun=1. Repeat with ready=1 -> overrun stays 0 and valid pulses every 16 cycles.

Source files
------------

// File: rtl/bsdec_pkg.sv
// Shared state encoding and default sizing for the stochastic bitstream decoder.
package bsdec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } bsdec_state_e;

  localparam int BSDEC_WINDOW_LOG2 = 16;
  localparam int BSDEC_OUT_WIDTH   = 8;

endpackage

// File: rtl/bitstream_decoder.sv
// Counts ones of a unipolar stochastic bitstream over a 2^WINDOW_LOG2 window and reports a scaled result.
// Build option BSDEC_CONTINUOUS_EN: back-to-back windows with a sticky overrun flag.
module bitstream_decoder
  import bsdec_pkg::*;
#(
  parameter int WINDOW_LOG2 = BSDEC_WINDOW_LOG2,
  parameter int OUT_WIDTH   = BSDEC_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 x,
  output logic [OUT_WIDTH-1:0] y,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_COUNT = COUNT;
  localparam logic [1:0] S_DONE  = DONE;

  // Largest value y can hold, widened to the ones-counter width for comparison.
  localparam logic [WINDOW_LOG2:0] SAT_LIMIT =
    {{(WINDOW_LOG2 + 1 - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  logic [1:0]             state_r;
  logic [WINDOW_LOG2-1:0] sample_cnt_r;
  logic [WINDOW_LOG2:0]   ones_cnt_r;
  logic [OUT_WIDTH-1:0]   y_r;
  logic                   valid_r;
  logic                   busy_r;

  logic [WINDOW_LOG2:0]   ones_next_s;
  logic [WINDOW_LOG2:0]   shifted_s;
  logic [OUT_WIDTH-1:0]   y_scaled_s;
  logic                   window_end_s;

  // Next ones count including this cycle's sample, and the saturated scaled result.
  always_comb begin
    ones_next_s  = ones_cnt_r + {{WINDOW_LOG2{1'b0}}, x};
    window_end_s = (sample_cnt_r == {WINDOW_LOG2{1'b1}});
    shifted_s    = ones_next_s >> (WINDOW_LOG2 - OUT_WIDTH);
    if (shifted_s > SAT_LIMIT) begin
      y_scaled_s = {OUT_WIDTH{1'b1}};
    end else begin
      y_scaled_s = shifted_s[OUT_WIDTH-1:0];
    end
  end

`ifdef BSDEC_CONTINUOUS_EN
  logic overrun_r;
`endif

  // Window FSM, counters and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      sample_cnt_r <= '0;
      ones_cnt_r   <= '0;
      y_r          <= '0;
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
`ifdef BSDEC_CONTINUOUS_EN
      overrun_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r      <= S_COUNT;
            sample_cnt_r <= '0;
            ones_cnt_r   <= '0;
            busy_r       <= 1'b1;
          end
        end
        S_COUNT: begin
          // The sample counter wraps to zero at window end, which also primes the next window.
          sample_cnt_r <= sample_cnt_r + WINDOW_LOG2'(1);
          ones_cnt_r   <= ones_next_s;
          if (window_end_s) begin
            ones_cnt_r <= '0;
            y_r        <= y_scaled_s;
            valid_r    <= 1'b1;
`ifdef BSDEC_CONTINUOUS_EN
            if (valid_r && !ready) begin
              overrun_r <= 1'b1;
            end
`else
            state_r    <= S_DONE;
            busy_r     <= 1'b0;
`endif
          end
`ifdef BSDEC_CONTINUOUS_EN
          else if (valid_r && ready) begin
            valid_r <= 1'b0;
          end
`endif
        end
        S_DONE: begin
          if (valid_r && ready) begin
            valid_r <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign y     = y_r;
  assign valid = valid_r;
  assign busy  = busy_r;
`ifdef BSDEC_CONTINUOUS_EN
  assign overrun = overrun_r;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed self-checking bench: a default-size decoder for the saturation case and a
// WINDOW_LOG2=4/OUT_WIDTH=4 decoder for the remaining scenarios.
module tb_bitstream_decoder;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;

  // Small decoder (WINDOW_LOG2=4, OUT_WIDTH=4)
  logic       start = 1'b0;
  logic       x_drv = 1'b0;
  logic       gen_en = 1'b0;
  logic       x_s;
  logic       ready = 1'b0;
  logic [3:0] y;
  logic       valid;
  logic       busy;
  logic       overrun;

  // Default-size decoder
  logic       start_a = 1'b0;
  logic       x_a = 1'b0;
  logic       ready_a = 1'b0;
  logic [7:0] y_a;
  logic       valid_a;
  logic       busy_a;
  logic       overrun_a;

  // generator16: free-running 16-bit counter, bit-reversed and compared with a threshold;
  // any 16 consecutive samples contain exactly threshold/4096 ones.
  logic [15:0] gen_cnt = 16'd0;
  logic [15:0] gen_rev;
  logic [15:0] gen_thr = 16'hC000;
  always @(posedge clk) gen_cnt <= gen_cnt + 16'd1;
  always_comb begin
    for (int b = 0; b < 16; b++) gen_rev[b] = gen_cnt[15-b];
  end
  assign x_s = gen_en ? (gen_rev < gen_thr) : x_drv;

  bitstream_decoder #(.WINDOW_LOG2(4), .OUT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x_s), .y(y),
    .valid(valid), .ready(ready), .busy(busy), .overrun(overrun)
  );

  bitstream_decoder dut_a (
    .clk(clk), .rst(rst), .start(start_a), .x(x_a), .y(y_a),
    .valid(valid_a), .ready(ready_a), .busy(busy_a), .overrun(overrun_a)
  );

  task automatic step();
    @(negedge clk);
  endtask

  // Start a window on the small decoder and feed 16 samples; returns at the cycle valid should rise.
  task automatic drive_window(input logic [15:0] pat, input logic use_gen, output int busy_cnt);
    busy_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    gen_en = use_gen;
    for (int i = 0; i < 16; i++) begin
      if (busy === 1'b1) busy_cnt++;
      x_drv = pat[i];
      step();
    end
    gen_en = 1'b0;
    x_drv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    start_a = 1'b1;
    step();
    step();
    rst = 1'b0;
    start = 1'b0;
    start_a = 1'b0;
    step();
    checks++;
    if ({y, valid, busy, overrun} !== 7'd0) begin
      failures++;
      $display("FAIL reset_small: y=%0d valid=%b busy=%b overrun=%b, required all 0", y, valid, busy, overrun);
    end
    checks++;
    if ({y_a, valid_a, busy_a, overrun_a} !== 11'd0) begin
      failures++;
      $display("FAIL reset_default: y=%0d valid=%b busy=%b overrun=%b, required all 0", y_a, valid_a, busy_a, overrun_a);
    end
  endtask

  task automatic test_saturation();
    int busy_cnt;
    busy_cnt = 0;
    ready_a = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    x_a = 1'b1;
    for (int i = 0; i < 70000 && valid_a !== 1'b1; i++) begin
      if (busy_a === 1'b1) busy_cnt++;
      step();
    end
    checks++;
    if (valid_a !== 1'b1 || y_a !== 8'd255) begin
      failures++;
      $display("FAIL sat_result: valid=%b y=%0d, required valid=1 y=255", valid_a, y_a);
    end
    checks++;
    if (busy_cnt !== 65536) begin
      failures++;
      $display("FAIL sat_busy_len: busy cycles=%0d, required 65536", busy_cnt);
    end
    step();
    checks++;
    if (valid_a !== 1'b0) begin
      failures++;
      $display("FAIL sat_valid_pulse: valid=%b one cycle after result, required 0", valid_a);
    end
    x_a = 1'b0;
    ready_a = 1'b0;
  endtask

  task automatic test_patterns();
    int busy_cnt;
    logic [15:0] pats [3];
    logic [3:0]  exp_y [3];
    pats[0] = 16'h0000; exp_y[0] = 4'd0;
    pats[1] = 16'h5555; exp_y[1] = 4'd8;
    pats[2] = 16'h0003; exp_y[2] = 4'd2;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_window(pats[k], 1'b0, busy_cnt);
      checks++;
      if (valid !== 1'b1 || y !== exp_y[k] || busy !== 1'b0) begin
        failures++;
        $display("FAIL pattern_%0d: valid=%b y=%0d busy=%b, required valid=1 y=%0d busy=0", k, valid, y, busy, exp_y[k]);
      end
      checks++;
      if (busy_cnt !== 16) begin
        failures++;
        $display("FAIL pattern_%0d_busy: busy cycles=%0d, required 16", k, busy_cnt);
      end
      step();
      checks++;
      if (valid !== 1'b0) begin
        failures++;
        $display("FAIL pattern_%0d_accept: valid=%b after accept, required 0", k, valid);
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_generator();
    int busy_cnt;
    ready = 1'b1;
    drive_window(16'h0000, 1'b1, busy_cnt);
    checks++;
    if (valid !== 1'b1 || y < 4'd11 || y > 4'd13) begin
      failures++;
      $display("FAIL generator_p075: valid=%b y=%0d, required valid=1 y=12+-1", valid, y);
    end
    step();
    ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int busy_cnt;
    int bad;
    bad = 0;
    ready = 1'b0;
    drive_window(16'h7FFF, 1'b0, busy_cnt);
    for (int i = 0; i < 20; i++) begin
      if (valid !== 1'b1 || y !== 4'd15) bad++;
      start = (i == 5) ? 1'b1 : 1'b0;
      step();
    end
    start = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hold_stable: %0d unstable cycles, required 0 (valid=1 y=15)", bad);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: valid=%b after ready, required 0", valid);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL hold_idle: busy=%b valid=%b overrun=%b, required 0 0 0", busy, valid, overrun);
    end
  endtask

  task automatic test_mid_reset();
    int busy_cnt;
    int bad;
    bad = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      x_drv = 1'b1;
      step();
    end
    rst = 1'b1;
    ready = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({y, valid, busy, overrun} !== 7'd0) begin
      failures++;
      $display("FAIL midrst_clear: y=%0d valid=%b busy=%b overrun=%b, required all 0", y, valid, busy, overrun);
    end
    for (int i = 0; i < 20; i++) begin
      if (valid !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    x_drv = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL midrst_quiet: %0d cycles with valid/busy, required 0", bad);
    end
    drive_window(16'h0003, 1'b0, busy_cnt);
    checks++;
    if (valid !== 1'b1 || y !== 4'd2) begin
      failures++;
      $display("FAIL midrst_restart: valid=%b y=%0d, required valid=1 y=2", valid, y);
    end
    step();
    ready = 1'b0;
  endtask

  task automatic test_continuous();
    int vcount;
    int bad;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready = 1'b0;
    x_drv = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) step();
    checks++;
    if (valid !== 1'b1 || y !== 4'd15 || overrun !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL cont_first: valid=%b y=%0d overrun=%b busy=%b, required 1 15 0 1", valid, y, overrun, busy);
    end
    for (int i = 0; i < 16; i++) step();
    checks++;
    if (overrun !== 1'b1 || valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL cont_overrun: overrun=%b valid=%b busy=%b, required 1 1 1", overrun, valid, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    vcount = 0;
    bad = 0;
    for (int n = 1; n <= 50; n++) begin
      if (valid === 1'b1) vcount++;
      if (valid !== ((n % 16) == 0 && n >= 16)) bad++;
      if (overrun !== 1'b0 || busy !== 1'b1) bad++;
      step();
    end
    checks++;
    if (vcount !== 3 || bad !== 0) begin
      failures++;
      $display("FAIL cont_ready: valid pulses=%0d bad cycles=%0d, required 3 and 0", vcount, bad);
    end
    x_drv = 1'b0;
    ready = 1'b0;
  endtask

  initial begin
    step();
    test_reset();
    test_saturation();
`ifdef BSDEC_CONTINUOUS_EN
    test_continuous();
`else
    test_patterns();
    test_generator();
    test_backpressure();
    test_mid_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
